// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT transmit scheduler slice.
// Holds the scheduler state encoding, requester count and SENT format codes.
package sent_pkg;

  localparam int NREQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_ACK        = 3'd4
  } state_e;

  localparam logic CH_SERIAL   = 1'b0;
  localparam logic CH_ENHANCED = 1'b1;

  // Fast-channel frame-format codes H.1 .. H.7.
  localparam logic [2:0] FC_FMT_H1 = 3'd1;
  localparam logic [2:0] FC_FMT_H2 = 3'd2;
  localparam logic [2:0] FC_FMT_H3 = 3'd3;
  localparam logic [2:0] FC_FMT_H4 = 3'd4;
  localparam logic [2:0] FC_FMT_H5 = 3'd5;
  localparam logic [2:0] FC_FMT_H6 = 3'd6;
  localparam logic [2:0] FC_FMT_H7 = 3'd7;

  function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/sent_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr+1 and wraps.
module sent_rr_arbiter
  import sent_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any_req
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt_idx = 2'd0;
    any_req = |req;
    found   = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sent_tx_scheduler.sv
// Shares one SENT transmit controller between four requesters with
// round-robin arbitration, one-shot launch, completion ack and a watchdog.
module sent_tx_scheduler
  import sent_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_fmt,
  input  logic [3:0]  req_cfg,
  input  logic [31:0] req_id,
  input  logic [63:0] req_data,
  input  logic        pause_en,
  input  logic        tx_idle,
  output logic        tx_enable,
  output logic        tx_channel_format,
  output logic        tx_config_bit,
  output logic        tx_optional_pause,
  output logic [7:0]  tx_id,
  output logic [15:0] tx_data_bit_field,
  output logic [3:0]  req_ack,
  output logic        busy,
  output logic [1:0]  grant_idx,
  output logic        err_timeout,
  output logic        err_flag,
  output logic [2:0]  dbg_state_o
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);

  // Handshake: a requester holds req_valid[i] high until it sees the
  // one-cycle req_ack[i]; the acked bit is masked during that cycle so a
  // late drop can never be picked a second time.

  state_e      state_q;
  logic [1:0]  rr_ptr_q;
  logic [15:0] wd_q, wd_d;
  logic        tx_enable_q, tx_fmt_q, tx_cfg_q, tx_pause_q;
  logic [7:0]  tx_id_q;
  logic [15:0] tx_data_q;
  logic [3:0]  req_ack_q;
  logic        busy_q, err_to_q, err_flag_q;
  logic [1:0]  grant_q;

  logic [3:0]  arb_req;
  logic [1:0]  arb_idx;
  logic        arb_any;

  assign arb_req = req_valid & ~req_ack_q;
  assign wd_d    = wd_q + 16'd1;

  sent_rr_arbiter u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'd3;
      wd_q        <= 16'd0;
      tx_enable_q <= 1'b0;
      tx_fmt_q    <= 1'b0;
      tx_cfg_q    <= 1'b0;
      tx_pause_q  <= 1'b0;
      tx_id_q     <= 8'd0;
      tx_data_q   <= 16'd0;
      req_ack_q   <= 4'd0;
      busy_q      <= 1'b0;
      grant_q     <= 2'd0;
      err_to_q    <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      tx_enable_q <= 1'b0;
      req_ack_q   <= 4'd0;
      err_to_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q     <= arb_idx;
            tx_fmt_q    <= req_fmt[arb_idx];
            tx_cfg_q    <= req_cfg[arb_idx];
            tx_id_q     <= req_id[{arb_idx, 3'b000} +: 8];
            tx_data_q   <= req_data[{arb_idx, 4'b0000} +: 16];
            tx_pause_q  <= pause_en;
            tx_enable_q <= 1'b1;
            busy_q      <= 1'b1;
            wd_q        <= 16'd0;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state_q <= ST_WAIT_START;
        ST_WAIT_START, ST_WAIT_DONE: begin
          // Watchdog expiry wins over a same-cycle idle transition.
          if (wd_q == WD_LIMIT) begin
            err_to_q   <= 1'b1;
            err_flag_q <= 1'b1;
            rr_ptr_q   <= grant_q;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            wd_q <= wd_d;
            if (state_q == ST_WAIT_START && !tx_idle) state_q <= ST_WAIT_DONE;
            else if (state_q == ST_WAIT_DONE && tx_idle) state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          req_ack_q <= idx_onehot(grant_q);
          rr_ptr_q  <= grant_q;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_enable         = tx_enable_q;
  assign tx_channel_format = tx_fmt_q;
  assign tx_config_bit     = tx_cfg_q;
  assign tx_optional_pause = tx_pause_q;
  assign tx_id             = tx_id_q;
  assign tx_data_bit_field = tx_data_q;
  assign req_ack           = req_ack_q;
  assign busy              = busy_q;
  assign grant_idx         = grant_q;
  assign err_timeout       = err_to_q;
  assign err_flag          = err_flag_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_sent_tx_scheduler.sv
// Directed bench for sent_tx_scheduler with a transaction-level reference model.
module tb_sent_tx_scheduler;

  localparam int TO = 16;

  logic        clk_tx, reset_tx;
  logic [3:0]  req_valid, req_fmt, req_cfg;
  logic [31:0] req_id;
  logic [63:0] req_data;
  logic        pause_en, tx_idle;
  logic        tx_enable, tx_channel_format, tx_config_bit, tx_optional_pause;
  logic [7:0]  tx_id;
  logic [15:0] tx_data_bit_field;
  logic [3:0]  req_ack;
  logic        busy, err_timeout, err_flag;
  logic [1:0]  grant_idx;
  logic [2:0]  dbg_state;

  sent_tx_scheduler #(.TIMEOUT_CYC(TO)) dut (
    .clk_tx(clk_tx), .reset_tx(reset_tx), .req_valid(req_valid), .req_fmt(req_fmt),
    .req_cfg(req_cfg), .req_id(req_id), .req_data(req_data), .pause_en(pause_en),
    .tx_idle(tx_idle), .tx_enable(tx_enable), .tx_channel_format(tx_channel_format),
    .tx_config_bit(tx_config_bit), .tx_optional_pause(tx_optional_pause), .tx_id(tx_id),
    .tx_data_bit_field(tx_data_bit_field), .req_ack(req_ack), .busy(busy),
    .grant_idx(grant_idx), .err_timeout(err_timeout), .err_flag(err_flag),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk_tx = 1'b0;
  always #5 clk_tx = ~clk_tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [3:0] exp_q[$];

  // reference model: expected output values plus transaction progress
  logic        e_en, e_fmt, e_cfg, e_pause, e_to, e_flag;
  logic [7:0]  e_id;
  logic [15:0] e_data;
  logic [3:0]  e_ack;
  logic [1:0]  e_gi;
  int          m_ptr;
  logic        m_busy, m_launched, m_started, m_finished;
  int          m_wait;

  // stimulus helpers
  logic resp_on, auto_drop;
  int   resp_cnt, en_cnt, en_cyc, g1_cnt;
  logic [7:0]  id_at_en;
  logic [15:0] data_at_en;
  logic        fmt_at_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    {e_en, e_fmt, e_cfg, e_pause, e_to, e_flag} = '0;
    e_id = '0; e_data = '0; e_ack = '0; e_gi = '0;
    m_ptr = 3; m_busy = 0; m_launched = 0; m_started = 0; m_finished = 0; m_wait = 0;
  endtask

  // Called once per clock edge with the inputs that edge sampled.
  task automatic model_advance();
    logic [3:0] pend;
    if (reset_tx) begin
      model_reset();
      return;
    end
    pend = req_valid & ~e_ack;
    e_en = 0; e_to = 0; e_ack = 0;
    if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (!m_busy && pend[idx]) begin
          m_busy = 1; e_gi = 2'(idx); e_en = 1;
          e_fmt = req_fmt[idx]; e_cfg = req_cfg[idx]; e_pause = pause_en;
          e_id = req_id[idx*8 +: 8]; e_data = req_data[idx*16 +: 16];
          m_launched = 0; m_started = 0; m_finished = 0; m_wait = 0;
        end
      end
    end else if (!m_launched) begin
      m_launched = 1;
    end else if (m_finished) begin
      e_ack = 4'b0001 << e_gi; m_busy = 0; m_ptr = int'(e_gi);
    end else if (m_wait == TO - 1) begin
      e_to = 1; e_flag = 1; m_busy = 0; m_ptr = int'(e_gi);
    end else begin
      m_wait++;
      if (!m_started) begin
        if (!tx_idle) m_started = 1;
      end else if (tx_idle) m_finished = 1;
    end
  endtask

  task automatic compare_all();
    check("tx_enable", tx_enable, e_en);
    check("tx_channel_format", tx_channel_format, e_fmt);
    check("tx_config_bit", tx_config_bit, e_cfg);
    check("tx_optional_pause", tx_optional_pause, e_pause);
    check("tx_id", tx_id, e_id);
    check("tx_data_bit_field", tx_data_bit_field, e_data);
    check("req_ack", req_ack, e_ack);
    check("busy", busy, m_busy);
    check("grant_idx", grant_idx, e_gi);
    check("err_timeout", err_timeout, e_to);
    check("err_flag", err_flag, e_flag);
    check("ack_onehot0", $countones(req_ack) <= 1, 1);
  endtask

  // One clock: model follows the edge, outputs are checked, then inputs move.
  task automatic step();
    @(negedge clk_tx);
    cyc++;
    model_advance();
    compare_all();
    if (tx_enable) begin
      en_cnt++; en_cyc = cyc;
      id_at_en = tx_id; data_at_en = tx_data_bit_field; fmt_at_en = tx_channel_format;
      if (grant_idx == 2'd1) g1_cnt++;
    end
    if (auto_drop) req_valid = req_valid & ~req_ack;
    if (resp_on) begin
      case (resp_cnt)
        0: if (tx_enable) resp_cnt = 1;
        1: begin tx_idle = 1'b0; resp_cnt = 2; end
        2: resp_cnt = 3;
        default: begin tx_idle = 1'b1; resp_cnt = 0; end
      endcase
    end
  endtask

  task automatic run_until_ack(input int budget, output logic [3:0] ack, output int ack_cyc);
    logic got;
    got = 0; ack = '0; ack_cyc = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (req_ack != 4'd0) begin ack = req_ack; ack_cyc = cyc; got = 1; end
    end
    check("ack_seen", got, 1);
  endtask

  task automatic run_until_enable(input int budget);
    logic got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (tx_enable) got = 1;
    end
    check("enable_seen", got, 1);
  endtask

  task automatic run_until_wait_done(input int budget);
    logic got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (resp_cnt == 3) got = 1;
    end
    check("wait_done_seen", got, 1);
  endtask

  initial begin
    logic [3:0] a;
    int ac, to_cyc, acks_seen;
    logic to_got;
    reset_tx = 1'b1;
    req_valid = '0; pause_en = 0; tx_idle = 1'b1;
    req_fmt  = 4'b0100;
    req_cfg  = 4'($urandom_range(0, 15));
    req_id   = {8'hD3, 8'h5A, 8'h21, 8'h10};
    req_data = {16'hBEEF, 16'h0001, 16'h1234, 16'hA5A5};
    resp_on = 1; auto_drop = 1; resp_cnt = 0; en_cnt = 0; en_cyc = 0; g1_cnt = 0;
    id_at_en = '0; data_at_en = '0; fmt_at_en = 0;
    model_reset();
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_outputs", {tx_enable, tx_id, tx_data_bit_field, req_ack, err_flag}, 0);
    reset_tx = 1'b0;

    // single requester 2
    step();
    req_valid = 4'b0100; en_cnt = 0;
    run_until_ack(20, a, ac);
    check("r2_ack", a, 4'b0100);
    check("r2_enable_pulses", en_cnt, 1);
    check("r2_tx_id", id_at_en, 8'h5A);
    check("r2_tx_data", data_at_en, 16'h0001);
    check("r2_fmt", fmt_at_en, 1);
    check("r2_pick_to_ack", ac - en_cyc, 5);

    // all four after reset: 0,1,2,3,0
    reset_tx = 1'b1; step(); reset_tx = 1'b0;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_until_ack(30, a, ac);
      if (n == 0) req_valid[0] = 1'b1;
      check("rr_order", a, exp_q.pop_front());
    end

    // watchdog: tx_idle stuck low, reqs 1 and 2 pending (ptr=0)
    resp_on = 0; tx_idle = 1'b0; req_valid = 4'b0110;
    to_got = 0; to_cyc = 0; acks_seen = 0;
    for (int i = 0; i < 40 && !to_got; i++) begin
      step();
      if (req_ack != 0) acks_seen++;
      if (err_timeout) begin to_got = 1; to_cyc = cyc; end
    end
    check("to_seen", to_got, 1);
    check("to_latency", to_cyc - en_cyc, 17);
    check("to_flag", err_flag, 1);
    check("to_no_ack", acks_seen, 0);
    tx_idle = 1'b1; resp_on = 1; resp_cnt = 0;
    run_until_ack(30, a, ac);
    check("after_to_next", a, 4'b0100);
    run_until_ack(30, a, ac);
    check("after_to_retry", a, 4'b0010);

    // reset during WAIT_DONE
    req_valid = 4'b1000;
    run_until_wait_done(20);
    reset_tx = 1'b1;
    #1;
    check("async_rst_outputs",
          {tx_enable, tx_channel_format, tx_config_bit, tx_optional_pause, tx_id,
           tx_data_bit_field, req_ack, busy, grant_idx, err_timeout, err_flag}, 0);
    model_reset();
    resp_cnt = 0; tx_idle = 1'b1; req_valid = 4'b1001;
    step(); step();
    reset_tx = 1'b0;
    run_until_ack(30, a, ac);
    check("post_rst_first", a, 4'b0001);
    run_until_ack(30, a, ac);
    check("post_rst_second", a, 4'b1000);

    // req 1 dropped in LAUNCH still completes
    req_valid = 4'b0010;
    run_until_enable(10);
    req_valid[1] = 1'b0;
    run_until_ack(30, a, ac);
    check("drop_in_launch_ack", a, 4'b0010);

    // req 1 raised and dropped while busy: never granted
    g1_cnt = 0;
    req_valid = 4'b0100;
    run_until_enable(10);
    req_valid[1] = 1'b1;
    step(); step();
    req_valid[1] = 1'b0;
    run_until_ack(30, a, ac);
    check("drop_busy_other_ack", a, 4'b0100);
    for (int i = 0; i < 10; i++) step();
    check("dropped_never_granted", g1_cnt, 0);

    // pause latched at pick, toggled mid-frame
    pause_en = 1'b1; req_valid = 4'b0001;
    run_until_enable(10);
    check("pause_at_launch", tx_optional_pause, 1);
    run_until_wait_done(10);
    pause_en = 1'b0;
    run_until_ack(30, a, ac);
    check("pause_held", tx_optional_pause, 1);
    check("pause_ack", a, 4'b0001);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
